// File: rtl/simon_seq_engine.sv
// simon_seq_engine: sequence engine for a four-lamp memory game.
// The engine appends a random step, replays the whole sequence on the lamps,
// then waits for the player to repeat it within a timeout.
//
// Optional feature: define SIMON_ECHO_EN to echo each correct player press on
// simon_num/simon_pressed for one cycle. Without it, simon_pressed stays low
// while waiting, and simon_num keeps the last value shown.
//
// Strobe semantics: start and player_pressed are single-cycle strobes. They
// are sampled on the rising clk edge and need no acknowledge. start only acts
// in IDLE or OVER. player_pressed only acts in WAIT, and player_num is
// qualified by it.
//
// dbgState exposes the FSM state encoding so that checkers can bind to it:
// 0 IDLE, 1 ADD, 2 SHOW_ON, 3 SHOW_OFF, 4 WAIT, 5 OVER.
module simon_seq_engine #(
  parameter int BTN_W         = 2,
  parameter int MAX_LEVEL     = 16,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 30,
  parameter int TIMEOUT_TICKS = 120,
  localparam int LW           = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BTN_W-1:0] rand_in,
  input  logic [BTN_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LW-1:0]    level,
  output logic             game_over,
  output logic             win,
  output logic [2:0]       dbgState
);

  // Index width into the sequence memory. It is at least 1 bit.
  localparam int IW    = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  // One shared tick counter serves the on, off and timeout phases.
  localparam int TMAX1 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX  = (TMAX1 > TIMEOUT_TICKS) ? TMAX1 : TIMEOUT_TICKS;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [BTN_W-1:0] mem [MAX_LEVEL];
  logic             isLast;

  assign dbgState = state;
  // The index is at the final entry of the current sequence.
  assign isLast   = ((LW'(idx) + LW'(1)) == level);

  // Sequence memory is not reset. In ADD, entry [level] is always a fresh
  // slot, so earlier steps are never overwritten within a game.
  always_ff @(posedge clk) begin
    if (state == S_ADD) begin
      mem[level[IW-1:0]] <= rand_in;
    end
  end

  // Game FSM. Every output is registered and updated together with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      simon_turn    <= 1'b0;
      simon_num     <= '0;
      simon_pressed <= 1'b0;
      level         <= '0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      idx           <= '0;
      timer         <= '0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          simon_pressed <= 1'b0;
          if (start) begin
            state      <= S_ADD;
            level      <= '0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            simon_turn <= 1'b1;
          end
        end

        S_ADD: begin
          // On the first level, mem[0] is written at this edge, so forward rand_in.
          state         <= S_SHOW_ON;
          level         <= level + LW'(1);
          idx           <= '0;
          timer         <= '0;
          simon_pressed <= 1'b1;
          simon_num     <= (level == '0) ? rand_in : mem[0];
        end

        S_SHOW_ON: begin
          if (timer == TW'(ON_TICKS - 1)) begin
            state         <= S_SHOW_OFF;
            simon_pressed <= 1'b0;
            timer         <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_SHOW_OFF: begin
          if (timer == TW'(OFF_TICKS - 1)) begin
            timer <= '0;
            if (isLast) begin
              state      <= S_WAIT;
              idx        <= '0;
              simon_turn <= 1'b0;
            end else begin
              state         <= S_SHOW_ON;
              idx           <= idx + IW'(1);
              simon_pressed <= 1'b1;
              simon_num     <= mem[idx + IW'(1)];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_WAIT: begin
          simon_pressed <= 1'b0;
          // A press beats the timeout, even on the final timeout cycle.
          if (player_pressed) begin
            if (player_num == mem[idx]) begin
              timer <= '0;
`ifdef SIMON_ECHO_EN
              simon_pressed <= 1'b1;
              simon_num     <= player_num;
`endif
              if (isLast) begin
                idx <= '0;
                if (level == LW'(MAX_LEVEL)) begin
                  state     <= S_OVER;
                  win       <= 1'b1;
                  game_over <= 1'b1;
                end else begin
                  state      <= S_ADD;
                  simon_turn <= 1'b1;
                end
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              state     <= S_OVER;
              win       <= 1'b0;
              game_over <= 1'b1;
            end
          end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
            state     <= S_OVER;
            win       <= 1'b0;
            game_over <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// tb_simon_seq_engine: scoreboard bench for simon_seq_engine with MAX_LEVEL=2.
// The expected lamp sequence is pushed when each step is appended. It is
// popped as each shown step appears on simon_num.
module tb_simon_seq_engine;

  localparam int BTN_W         = 2;
  localparam int MAX_LEVEL     = 2;
  localparam int ON_TICKS      = 30;
  localparam int OFF_TICKS     = 30;
  localparam int TIMEOUT_TICKS = 120;
  localparam int LW            = $clog2(MAX_LEVEL + 1);
`ifdef SIMON_ECHO_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic [BTN_W-1:0] rand_in;
  logic [BTN_W-1:0] player_num;
  logic             player_pressed;
  logic             simon_turn;
  logic [BTN_W-1:0] simon_num;
  logic             simon_pressed;
  logic [LW-1:0]    level;
  logic             game_over;
  logic             win;
  logic [2:0]       dbgState;

  int checks = 0;
  int errors = 0;

  logic [BTN_W-1:0] exp_q[$];
  logic [BTN_W-1:0] seqModel [MAX_LEVEL];
  int               seqLen;

  simon_seq_engine #(
    .BTN_W(BTN_W), .MAX_LEVEL(MAX_LEVEL), .ON_TICKS(ON_TICKS),
    .OFF_TICKS(OFF_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
    .player_num(player_num), .player_pressed(player_pressed),
    .simon_turn(simon_turn), .simon_num(simon_num),
    .simon_pressed(simon_pressed), .level(level), .game_over(game_over),
    .win(win), .dbgState(dbgState)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Append a step to the model and queue the full replay that follows it.
  task automatic queueReplay(input logic [BTN_W-1:0] r);
    seqModel[seqLen] = r;
    seqLen++;
    for (int i = 0; i < seqLen; i++) exp_q.push_back(seqModel[i]);
  endtask

  task automatic pressBtn(input logic [BTN_W-1:0] num);
    player_num     = num;
    player_pressed = 1'b1;
    @(negedge clk);
    player_pressed = 1'b0;
  endtask

  // Pulse start from IDLE/OVER. The task returns in the ADD cycle.
  task automatic startGame(input logic [BTN_W-1:0] r);
    seqLen  = 0;
    rand_in = r;
    queueReplay(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("start_state_add", dbgState, 1);
    checkVal("start_turn", simon_turn, 1);
    checkVal("start_level_clear", level, 0);
    checkVal("start_over_clear", game_over, 0);
  endtask

  // Observe one full replay. Check each step value against the scoreboard,
  // along with on/off lengths, the total show time and the level.
  task automatic runShow();
    int hi, lo, total, bound;
    logic [BTN_W-1:0] expv;
    total = 0;
    for (int k = 0; k < seqLen; k++) begin
      bound = 0;
      while (dbgState != 3'd2 && bound < 400) begin
        @(negedge clk);
        bound++;
      end
      checkVal("show_reached", dbgState, 2);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checkVal("show_num", simon_num, expv);
      hi = 0;
      while (simon_pressed && simon_turn && dbgState == 3'd2 && hi < 400) begin
        hi++;
        @(negedge clk);
      end
      checkVal("on_ticks", hi, ON_TICKS);
      lo = 0;
      while (!simon_pressed && dbgState == 3'd3 && lo < 400) begin
        lo++;
        @(negedge clk);
      end
      checkVal("off_ticks", lo, OFF_TICKS);
      total += hi + lo;
    end
    checkVal("turn_fall", simon_turn, 0);
    checkVal("wait_state", dbgState, 4);
    checkVal("show_total", total, seqLen * (ON_TICKS + OFF_TICKS));
    checkVal("show_level", level, seqLen);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; rand_in = '0; player_num = '0; player_pressed = 1'b0;
    seqLen = 0;
    cyc(2);
    checkVal("rst_turn", simon_turn, 0);
    checkVal("rst_num", simon_num, 0);
    checkVal("rst_pressed", simon_pressed, 0);
    checkVal("rst_level", level, 0);
    checkVal("rst_over", game_over, 0);
    checkVal("rst_win", win, 0);
    checkVal("rst_state", dbgState, 0);
    reset = 1'b0;
    cyc(1);

    // Level 1 with rand 2.
    startGame(2'd2);
    runShow();

    // Correct press grows the game to level 2; the new random step is 1.
    rand_in = 2'd1;
    queueReplay(2'd1);
    pressBtn(2'd2);
    checkVal("grow_state_add", dbgState, 1);
    checkVal("grow_turn", simon_turn, 1);
    checkVal("grow_echo", simon_pressed, ECHO);
    checkVal("grow_over", game_over, 0);
    runShow();

    // Full correct replay of level 2 wins (MAX_LEVEL=2).
    pressBtn(2'd2);
    checkVal("mid_echo_pressed", simon_pressed, ECHO);
    checkVal("mid_echo_num", simon_num, ECHO ? 2 : 1);
    cyc(5);
    checkVal("mid_pressed_low", simon_pressed, 0);
    checkVal("mid_over", game_over, 0);
    pressBtn(2'd1);
    checkVal("win_over", game_over, 1);
    checkVal("win_win", win, 1);
    checkVal("win_level", level, 2);
    checkVal("win_turn", simon_turn, 0);

    // OVER holds; presses are ignored.
    pressBtn(2'd3);
    cyc(10);
    checkVal("hold_over", game_over, 1);
    checkVal("hold_win", win, 1);
    checkVal("hold_level", level, 2);

    // Restart, then press the wrong button.
    startGame(2'd3);
    runShow();
    pressBtn(2'd0);
    checkVal("wrong_over", game_over, 1);
    checkVal("wrong_win", win, 0);
    checkVal("wrong_level", level, 1);

    // Timeout after 120 idle WAIT cycles.
    startGame(2'd1);
    runShow();
    cyc(TIMEOUT_TICKS - 1);
    checkVal("timeout_early", game_over, 0);
    cyc(1);
    checkVal("timeout_over", game_over, 1);
    checkVal("timeout_win", win, 0);
    checkVal("timeout_level", level, 1);

    // A press on the last timeout cycle wins over the timeout.
    startGame(2'd0);
    runShow();
    cyc(TIMEOUT_TICKS - 1);
    rand_in = 2'(($urandom_range(0, 3)));
    queueReplay(rand_in);
    pressBtn(2'd0);
    checkVal("late_press_over", game_over, 0);
    checkVal("late_press_add", dbgState, 1);
    runShow();
    checkVal("sb_drained", exp_q.size(), 0);

    // Lose, start again, then send stray start/press pulses during the show.
    pressBtn(seqModel[0] + 2'd1);
    checkVal("lose2_over", game_over, 1);
    startGame(2'd1);
    cyc(1);
    start = 1'b1; player_pressed = 1'b1; player_num = 2'd3;
    cyc(1);
    start = 1'b0; player_pressed = 1'b0;
    checkVal("ignore_state", dbgState, 2);
    checkVal("ignore_level", level, 1);
    checkVal("ignore_over", game_over, 0);
    checkVal("ignore_pressed", simon_pressed, 1);

    // Asynchronous reset in SHOW_ON clears the outputs immediately.
    #2 reset = 1'b1;
    #1;
    checkVal("arst_turn", simon_turn, 0);
    checkVal("arst_num", simon_num, 0);
    checkVal("arst_pressed", simon_pressed, 0);
    checkVal("arst_level", level, 0);
    checkVal("arst_over", game_over, 0);
    checkVal("arst_win", win, 0);
    checkVal("arst_state", dbgState, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    checkVal("post_rst_idle", dbgState, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
